// File: rtl/sfp_pkg.sv
// Shared types and saturation helpers for the signed fixed-point add/sub pipeline.
// Helpers work on a 64-bit carrier so one function body serves any IW+QW < 64.
package sfp_pkg;

    typedef enum logic {
        SFP_OP_ADD = 1'b0,
        SFP_OP_SUB = 1'b1
    } sfp_op_e;

    localparam int SFP_XW = 64;

    function automatic logic [SFP_XW-1:0] sfp_max(input int iw, input int qw);
        return (SFP_XW'(1) << (iw + qw - 1)) - SFP_XW'(1);
    endfunction

    function automatic logic [SFP_XW-1:0] sfp_min(input int iw, input int qw);
        return SFP_XW'(1) << (iw + qw - 1);
    endfunction

    // s is the W+1-bit raw sum sign-extended to the carrier; returns {ovf, val}
    function automatic logic [SFP_XW:0] sfp_sat(input logic [SFP_XW:0] s, input logic clip,
                                                input int iw, input int qw);
        logic [6:0]        wi;
        logic              ovf;
        logic [SFP_XW-1:0] mask;
        logic [SFP_XW-1:0] val;
        wi   = 7'(iw + qw);
        ovf  = s[wi] ^ s[wi - 7'd1];
        mask = (SFP_XW'(1) << wi) - SFP_XW'(1);
        val  = s[SFP_XW-1:0] & mask;
        if (ovf && clip)
            val = s[wi] ? sfp_min(iw, qw) : sfp_max(iw, qw);
        return {ovf, val};
    endfunction

endpackage

// File: rtl/sfp_pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or draining, so no bubbles.
module sfp_pipe_stage
    import sfp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/sfp_addsub_pipe.sv
// Pipelined signed fixed-point add/sub with per-beat clip/wrap and valid/ready flow control.
// Optional overflow statistics counter is built only with SFP_ADDSUB_PIPE_STATS_EN defined.
module sfp_addsub_pipe
    import sfp_pkg::*;
#(
    parameter int IW     = 16,
    parameter int QW     = 16,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IW+QW-1:0]  in_a,
    input  logic [IW+QW-1:0]  in_b,
    input  logic              in_sub,
    input  logic              in_clip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW+QW-1:0]  out_val,
    output logic              out_clipping,
    output logic [15:0]       ovf_count,
    input  logic              ovf_clear
);

    localparam int W = IW + QW;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] rdy_pipe;
    logic [W:0]      res_pipe [1:STAGES];

    assign vld_pipe[0]      = in_valid;
    assign rdy_pipe[STAGES] = out_ready;
    assign in_ready         = rdy_pipe[0];

    // Stage 1: exact W+1-bit sum/difference plus the clip request
    sfp_op_e    op;
    logic [W:0] a_x, b_x, s_d;
    logic [W+1:0] s1_d, s1_q;

    assign op   = sfp_op_e'(in_sub);
    assign a_x  = {in_a[W-1], in_a};
    assign b_x  = {in_b[W-1], in_b};
    assign s_d  = (op == SFP_OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    assign s1_d = {in_clip, s_d};

    sfp_pipe_stage #(.DW(W + 2)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_pipe[0]),
        .in_ready  (rdy_pipe[0]),
        .in_data   (s1_d),
        .out_valid (vld_pipe[1]),
        .out_ready (rdy_pipe[1]),
        .out_data  (s1_q)
    );

    // Clip/wrap resolve feeds stage 2; the carrier bits above W are don't-care
    logic [SFP_XW:0]      sat_full;
    logic [SFP_XW-1:W]    unused_sat_hi;

    assign sat_full      = sfp_sat((SFP_XW + 1)'(signed'(s1_q[W:0])), s1_q[W+1], IW, QW);
    assign res_pipe[1]   = {sat_full[SFP_XW], sat_full[W-1:0]};
    assign unused_sat_hi = sat_full[SFP_XW-1:W];

    for (genvar k = 2; k <= STAGES; k++) begin : g_stage
        sfp_pipe_stage #(.DW(W + 1)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld_pipe[k-1]),
            .in_ready  (rdy_pipe[k-1]),
            .in_data   (res_pipe[k-1]),
            .out_valid (vld_pipe[k]),
            .out_ready (rdy_pipe[k]),
            .out_data  (res_pipe[k])
        );
    end

    assign out_valid    = vld_pipe[STAGES];
    assign out_val      = res_pipe[STAGES][W-1:0];
    assign out_clipping = res_pipe[STAGES][W];

`ifdef SFP_ADDSUB_PIPE_STATS_EN
    logic [15:0] ovf_cnt_q;

    // Counts delivered overflowing results; clear has priority over a same-cycle hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt_q <= '0;
        else if (ovf_clear)
            ovf_cnt_q <= '0;
        else if (out_valid && out_ready && out_clipping && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_count = ovf_cnt_q;
`else
    logic unused_ovf_clear;

    assign ovf_count        = '0;
    assign unused_ovf_clear = ovf_clear;
`endif

endmodule

// File: tb/tb_sfp_addsub_pipe.sv
// Directed self-checking bench for sfp_addsub_pipe (IW=QW=16, STAGES=2).
module tb_sfp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        in_sub, in_clip;
    logic        out_valid, out_ready;
    logic [31:0] out_val;
    logic        out_clipping;
    logic [15:0] ovf_count;
    logic        ovf_clear;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sfp_addsub_pipe #(.IW(16), .QW(16), .STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_clip      (in_clip),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_val      (out_val),
        .out_clipping (out_clipping),
        .ovf_count    (ovf_count),
        .ovf_clear    (ovf_clear)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with an idle input; checks 2-cycle latency and result
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic clip,
                            input logic [31:0] ev, input logic ec);
        in_a = a; in_b = b; in_sub = sub; in_clip = clip;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, " valid"}, 64'(out_valid), 64'd1);
        check({tag, " val"}, 64'(out_val), 64'(ev));
        check({tag, " clipping"}, 64'(out_clipping), 64'(ec));
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp_q [6];
        logic [31:0] prev_val;
        logic        stalled_prev;
        int          c, ii, oi, held;
        logic        acc_in, acc_out;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_clip = 1'b0;
        out_ready = 1'b1; ovf_clear = 1'b0;
        #2;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_val", 64'(out_val), 64'd0);
        check("rst out_clipping", 64'(out_clipping), 64'd0);
        check("rst ovf_count", 64'(ovf_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Arithmetic vectors
        send_one("add",       32'h0001_8000, 32'h0002_4000, 1'b0, 1'b0, 32'h0003_C000, 1'b0);
        send_one("pos_clip",  32'h7FFF_0000, 32'h0002_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send_one("pos_wrap",  32'h7FFF_0000, 32'h0002_0000, 1'b0, 1'b0, 32'h8001_0000, 1'b1);
        send_one("neg_clip",  32'h8000_0000, 32'h0001_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
        send_one("neg_wrap",  32'h8000_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h7FFF_0000, 1'b1);
        send_one("0-min clip",32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send_one("0-min wrap",32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        send_one("sub neg",   32'h0000_1000, 32'h0000_3000, 1'b1, 1'b1, 32'hFFFF_E000, 1'b0);
        send_one("max+0",     32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0);
        send_one("-1+-1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        send_one("min+min wr",32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        send_one("min+min cl",32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        idle_cycle();

        // Backpressure: 6 beats, out_ready low for cycles 2..8
        for (int k = 0; k < 6; k++)
            exp_q[k] = k[0] ? ((32'(k + 1) << 16) - (32'(k + 1) << 8))
                            : ((32'(k + 1) << 16) + (32'(k + 1) << 8));
        c = 0; ii = 0; oi = 0; held = 0; stalled_prev = 1'b0; prev_val = '0;
        while (oi < 6 && c < 40) begin
            c++;
            out_ready = !(c >= 2 && c <= 8);
            if (ii < 6) begin
                in_valid = 1'b1;
                in_a     = 32'(ii + 1) << 16;
                in_b     = 32'(ii + 1) << 8;
                in_sub   = ii[0];
                in_clip  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp in_ready", 64'(in_ready), 64'(!(held == 2 && !out_ready)));
            if (stalled_prev) begin
                check("bp hold valid", 64'(out_valid), 64'd1);
                check("bp hold val", 64'(out_val), 64'(prev_val));
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                check("bp order", 64'(out_val), 64'(exp_q[oi]));
                oi++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_val     = out_val;
            if (acc_in) ii++;
            held = held + int'(acc_in) - int'(acc_out);
            @(posedge clk); #1;
        end
        check("bp delivered", 64'(oi), 64'd6);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp drained", 64'(out_valid), 64'd0);

        // Reset with two beats in flight
        in_a = 32'h7FFF_0000; in_b = 32'h0002_0000; in_sub = 1'b0; in_clip = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'h0001_0000; in_b = 32'h0001_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid valid pre", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid rst valid", 64'(out_valid), 64'd0);
        check("mid rst val", 64'(out_val), 64'd0);
        check("mid rst clip", 64'(out_clipping), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("mid no stale", 64'(out_valid), 64'd0);
        end
        send_one("post rst add", 32'h0001_8000, 32'h0002_4000, 1'b0, 1'b0, 32'h0003_C000, 1'b0);
        idle_cycle();

`ifdef SFP_ADDSUB_PIPE_STATS_EN
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check("stats cleared", 64'(ovf_count), 64'd0);
        for (int k = 0; k < 3; k++)
            send_one("stats ovf", 32'h7FFF_0000, 32'h0002_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        idle_cycle();
        check("stats count3", 64'(ovf_count), 64'd3);
        send_one("stats ovf4", 32'h7FFF_0000, 32'h0002_0000, 1'b0, 1'b0, 32'h8001_0000, 1'b1);
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check("stats clear wins", 64'(ovf_count), 64'd0);
`else
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check("stats tied0", 64'(ovf_count), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
